uart_ram_bridge: RTL and testbench
==================================

# uart_ram_bridge

Parametrised UART-to-RAM transfer engine between the byte-wide UART core and the processor's shared data RAM. It loads an instruction region or an image region from serial input, and dumps a result region to serial output. RAM words are DATA_W bits wide and move over the UART as DATA_W/8 bytes, most-significant byte first. Exactly one transfer runs at a time; start requests arriving while busy are ignored.

## Interface
- DATA_W, 16: RAM word width. Must be a multiple of 8 and at least 8. BYTES = DATA_W/8.
- ADDR_W, 16: RAM address width.
- TX_START, 34816 / TX_END, 51199: inclusive address range dumped on a send request.
- INS_START, 1 / INS_END, 44: inclusive address range loaded on an instruction-receive request.
- IMG_START, 128 / IMG_END, 33409: inclusive address range loaded on an image-receive request.
- All ranges require END >= START. Each END must fit in ADDR_W bits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- send, rec_in, rec_im  in  1  level start requests.
- abort  in  1  cancels the active transfer.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write strobe, one cycle per word.
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_addr changes.
- uart_tx_data  out  8  byte to transmit.
- uart_tx_start  out  1  one-cycle start pulse to the UART transmitter.
- uart_tx_done  in  1  one-cycle pulse when the UART finishes a byte.
- uart_rx_rdy  in  1  a received byte is available.
- uart_rx_data  in  8  the received byte.
- uart_rx_clr  out  1  one-cycle clear of uart_rx_rdy.
- busy  out  1  a transfer is active.
- tx_led, rxin_led, rxim_led  out  1  completion flags, one per mode.
- err  out  1  sticky error flag.

## Operation
Reset value of every output is 0: ram_addr, ram_wdata, ram_we, uart_tx_data, uart_tx_start, uart_rx_clr, busy, all LEDs and err. Reset also forces the FSM to IDLE, and applies mid-transfer too. A transfer cut by reset or abort leaves RAM partially written; no rollback.

FSM states are IDLE, TX_RD, TX_LD, TX_BYTE, TX_WAIT, RX_BYTE, RX_CLR, RX_WR, NEXT, CHK and DONE.

IDLE:
- Starts only on a rising edge of exactly one of send/rec_in/rec_im, where the other two are low in that cycle.
- Simultaneous edges, or an edge while busy, are ignored.
- A request held high does not restart the transfer.
- On a valid start: busy=1, the matching LED clears to 0, err clears to 0, and ram_addr loads the region's START address.
- The next state is TX_RD for a send, RX_BYTE for either receive.

Send path:
- TX_RD waits one cycle for RAM read data.
- TX_LD latches ram_rdata into a shift register and sets the byte counter to BYTES.
- TX_BYTE drives the top byte on uart_tx_data and pulses uart_tx_start.
- TX_WAIT waits for uart_tx_done, then shifts the register left 8 bits and decrements the counter. If bytes remain, it returns to TX_BYTE; otherwise it goes to NEXT.

Receive path:
- RX_BYTE waits for uart_rx_rdy, then shifts uart_rx_data into the low byte of ram_wdata (ram_wdata <= {ram_wdata[DATA_W-9:0], byte}) and pulses uart_rx_clr.
- RX_CLR waits for uart_rx_rdy to fall. If bytes remain, it returns to RX_BYTE; otherwise it goes to RX_WR.
- RX_WR pulses ram_we for one cycle, with ram_addr and ram_wdata stable, then goes to NEXT.

NEXT:
- If ram_addr equals the region END, go to CHK if the checksum is compiled in, otherwise to DONE.
- Otherwise increment ram_addr and return to TX_RD (send) or RX_BYTE (receive).
- ram_addr never wraps past END.

DONE: sets the matching LED to 1 and busy to 0, then returns to IDLE. LEDs hold until the next start of the same mode.

Abort: abort=1 in any non-IDLE state does the following in the next cycle:
- Go to IDLE with busy=0 and err=1.
- The LED stays 0.
- Pending strobes (ram_we, uart_tx_start, uart_rx_clr) are dropped.

## Timing
- Each strobe (ram_we, uart_tx_start, uart_rx_clr) is exactly one cycle wide.
- Start latency from the request edge: the first uart_tx_start comes 4 cycles later (IDLE→TX_RD→TX_LD→TX_BYTE). For a receive, the first byte is accepted in the cycle after entering RX_BYTE.
- A word write happens 2 cycles after its last byte is accepted.
- Per-word overhead beyond UART time: 4 cycles on send, 3 cycles on receive.
- Rising-edge detection uses a registered copy of each request, reset to 0. A request already high when reset releases therefore counts as an edge.

## Configuration
- UART_BRIDGE_CKSUM_EN defined:
  - An 8-bit XOR checksum accumulates over every byte transferred; it clears at start.
  - On send, CHK transmits the checksum byte using the normal start/done handshake.
  - On receive, CHK takes one extra byte. If it mismatches, err=1 and the LED is still set in DONE.
- UART_BRIDGE_CKSUM_EN undefined: NEXT goes straight to DONE, no extra byte is sent or expected, and err is set only by abort.

## Test plan
- DATA_W=16, INS 1..4: rec_in edge, then send bytes 12 34 56 78 9A BC DE F0. Required: RAM[1..4] = 1234, 5678, 9ABC, DEF0; four ram_we pulses; rxin_led=1; busy=0.
- DATA_W=16, TX 10..11 with RAM = A1B2, C3D4: send edge. Required: TX bytes A1 B2 C3 D4 in order; tx_led=1; address stops at 11.
- DATA_W=32, IMG 0..0: rec_im edge with bytes 01 02 03 04. Required: a single write of 01020304 to address 0.
- Simultaneous send and rec_im edges, then a send edge during a receive, then send held high after DONE. Required: no start or restart in any case; busy stays as before.
- Abort after 3 of 8 bytes, and separately rst_n=0 mid-send. Required: IDLE within 1 cycle, all strobes 0; the abort case sets err=1.
- With UART_BRIDGE_CKSUM_EN, INS 1..1: bytes 12 34 then 26 gives err=0. Repeating with 27 gives err=1 and rxin_led=1.

Source files
------------

// File: rtl/uart_ram_bridge.sv
// uart_ram_bridge: moves a RAM region to or from a byte-wide UART, one word at a time, MSB first.
// Define UART_BRIDGE_CKSUM_EN to append/verify a trailing 8-bit XOR checksum byte.
module uart_ram_bridge #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TX_START  = 34816,
  parameter int unsigned TX_END    = 51199,
  parameter int unsigned INS_START = 1,
  parameter int unsigned INS_END   = 44,
  parameter int unsigned IMG_START = 128,
  parameter int unsigned IMG_END   = 33409
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send,
  input  logic              rec_in,
  input  logic              rec_im,
  input  logic              abort,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_start,
  input  logic              uart_tx_done,
  input  logic              uart_rx_rdy,
  input  logic [7:0]        uart_rx_data,
  output logic              uart_rx_clr,
  output logic              busy,
  output logic              tx_led,
  output logic              rxin_led,
  output logic              rxim_led,
  output logic              err,
  output logic [3:0]        dbg_state
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(BYTES + 1);

  localparam logic [ADDR_W-1:0] TX_S  = ADDR_W'(TX_START);
  localparam logic [ADDR_W-1:0] TX_E  = ADDR_W'(TX_END);
  localparam logic [ADDR_W-1:0] INS_S = ADDR_W'(INS_START);
  localparam logic [ADDR_W-1:0] INS_E = ADDR_W'(INS_END);
  localparam logic [ADDR_W-1:0] IMG_S = ADDR_W'(IMG_START);
  localparam logic [ADDR_W-1:0] IMG_E = ADDR_W'(IMG_END);

  typedef enum logic [3:0] {
    ST_IDLE, ST_TX_RD, ST_TX_LD, ST_TX_BYTE, ST_TX_WAIT,
    ST_RX_BYTE, ST_RX_CLR, ST_RX_WR, ST_NEXT, ST_CHK, ST_DONE
  } state_t;

  typedef enum logic [1:0] {M_TX, M_INS, M_IMG} mode_t;

  // Handshakes: ram_we, uart_tx_start and uart_rx_clr are registered one-cycle
  // strobes; a byte is taken from the UART when uart_rx_rdy is high in RX_BYTE,
  // and the bridge then waits for uart_rx_rdy low before asking for the next.
  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [2:0]          req_q, req_d, rise;
  logic [ADDR_W-1:0]   addr_q, addr_d, end_addr;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                we_q, we_d;
  logic                tx_start_q, tx_start_d;
  logic                rx_clr_q, rx_clr_d;
  logic                busy_q, busy_d;
  logic                tx_led_q, tx_led_d;
  logic                rxin_led_q, rxin_led_d;
  logic                rxim_led_q, rxim_led_d;
  logic                err_q, err_d;
  logic                start_ok;
`ifdef UART_BRIDGE_CKSUM_EN
  logic [7:0]          cksum_q, cksum_d;
  logic                chk_q, chk_d;
`endif

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    we_d       = 1'b0;
    tx_start_d = 1'b0;
    rx_clr_d   = 1'b0;
    busy_d     = busy_q;
    tx_led_d   = tx_led_q;
    rxin_led_d = rxin_led_q;
    rxim_led_d = rxim_led_q;
    err_d      = err_q;
`ifdef UART_BRIDGE_CKSUM_EN
    cksum_d    = cksum_q;
    chk_d      = chk_q;
`endif
    req_d    = {send, rec_in, rec_im};
    rise     = req_d & ~req_q;
    // Exactly one fresh edge, with the other two requests low this cycle.
    start_ok = $onehot(rise) && (rise == req_d);

    case (mode_q)
      M_INS:   end_addr = INS_E;
      M_IMG:   end_addr = IMG_E;
      default: end_addr = TX_E;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          busy_d = 1'b1;
          err_d  = 1'b0;
          cnt_d  = CNT_W'(BYTES);
`ifdef UART_BRIDGE_CKSUM_EN
          cksum_d = 8'h00;
          chk_d   = 1'b0;
`endif
          if (rise[2]) begin
            mode_d   = M_TX;
            tx_led_d = 1'b0;
            addr_d   = TX_S;
            state_d  = ST_TX_RD;
          end else if (rise[1]) begin
            mode_d     = M_INS;
            rxin_led_d = 1'b0;
            addr_d     = INS_S;
            state_d    = ST_RX_BYTE;
          end else begin
            mode_d     = M_IMG;
            rxim_led_d = 1'b0;
            addr_d     = IMG_S;
            state_d    = ST_RX_BYTE;
          end
        end
      end
      ST_TX_RD: state_d = ST_TX_LD;
      ST_TX_LD: begin
        shift_d = ram_rdata;
        cnt_d   = CNT_W'(BYTES);
        state_d = ST_TX_BYTE;
      end
      ST_TX_BYTE: begin
        tx_data_d  = shift_q[DATA_W-1 -: 8];
        tx_start_d = 1'b1;
`ifdef UART_BRIDGE_CKSUM_EN
        cksum_d    = cksum_q ^ shift_q[DATA_W-1 -: 8];
`endif
        state_d    = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (uart_tx_done) begin
          shift_d = shift_q << 8;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? ST_NEXT : ST_TX_BYTE;
        end
      end
      ST_RX_BYTE: begin
        if (uart_rx_rdy) begin
          wdata_d  = (wdata_q << 8) | DATA_W'(uart_rx_data);
          rx_clr_d = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
`ifdef UART_BRIDGE_CKSUM_EN
          cksum_d  = cksum_q ^ uart_rx_data;
`endif
          state_d  = ST_RX_CLR;
        end
      end
      ST_RX_CLR: begin
        if (!uart_rx_rdy) state_d = (cnt_q == '0) ? ST_RX_WR : ST_RX_BYTE;
      end
      ST_RX_WR: begin
        we_d    = 1'b1;
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (addr_q == end_addr) begin
`ifdef UART_BRIDGE_CKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = CNT_W'(BYTES);
          state_d = (mode_q == M_TX) ? ST_TX_RD : ST_RX_BYTE;
        end
      end
      ST_CHK: begin
`ifdef UART_BRIDGE_CKSUM_EN
        // chk_q marks that the checksum byte has been sent or taken.
        if (mode_q == M_TX) begin
          if (!chk_q) begin
            tx_data_d  = cksum_q;
            tx_start_d = 1'b1;
            chk_d      = 1'b1;
          end else if (uart_tx_done) begin
            state_d = ST_DONE;
          end
        end else begin
          if (!chk_q) begin
            if (uart_rx_rdy) begin
              rx_clr_d = 1'b1;
              chk_d    = 1'b1;
              if (uart_rx_data != cksum_q) err_d = 1'b1;
            end
          end else if (!uart_rx_rdy) begin
            state_d = ST_DONE;
          end
        end
`else
        state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        busy_d = 1'b0;
        case (mode_q)
          M_INS:   rxin_led_d = 1'b1;
          M_IMG:   rxim_led_d = 1'b1;
          default: tx_led_d   = 1'b1;
        endcase
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      busy_d     = 1'b0;
      err_d      = 1'b1;
      we_d       = 1'b0;
      tx_start_d = 1'b0;
      rx_clr_d   = 1'b0;
      tx_led_d   = tx_led_q;
      rxin_led_d = rxin_led_q;
      rxim_led_d = rxim_led_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= M_TX;
      req_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      we_q       <= 1'b0;
      tx_start_q <= 1'b0;
      rx_clr_q   <= 1'b0;
      busy_q     <= 1'b0;
      tx_led_q   <= 1'b0;
      rxin_led_q <= 1'b0;
      rxim_led_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_BRIDGE_CKSUM_EN
      cksum_q    <= '0;
      chk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      we_q       <= we_d;
      tx_start_q <= tx_start_d;
      rx_clr_q   <= rx_clr_d;
      busy_q     <= busy_d;
      tx_led_q   <= tx_led_d;
      rxin_led_q <= rxin_led_d;
      rxim_led_q <= rxim_led_d;
      err_q      <= err_d;
`ifdef UART_BRIDGE_CKSUM_EN
      cksum_q    <= cksum_d;
      chk_q      <= chk_d;
`endif
    end
  end

  assign ram_addr      = addr_q;
  assign ram_wdata     = wdata_q;
  assign ram_we        = we_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_start = tx_start_q;
  assign uart_rx_clr   = rx_clr_q;
  assign busy          = busy_q;
  assign tx_led        = tx_led_q;
  assign rxin_led      = rxin_led_q;
  assign rxim_led      = rxim_led_q;
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_ram_bridge.sv
// Directed bench for uart_ram_bridge: three instances (16-bit, 32-bit, 16-bit single word)
// sharing one UART model; also exercises the checksum path when UART_BRIDGE_CKSUM_EN is defined.
`timescale 1ns/1ps
module tb_uart_ram_bridge;

`ifdef UART_BRIDGE_CKSUM_EN
  localparam int CK_N = 1;
`else
  localparam int CK_N = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // ---------------- shared UART wires ----------------
  logic       rx_rdy  = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done = 1'b0;

  // instance A: 16-bit, TX 10..11, INS 1..4, IMG 20..21
  logic a_send = 1'b0, a_rec_in = 1'b0, a_rec_im = 1'b0, a_abort = 1'b0;
  logic [7:0]  a_addr, a_txd;
  logic [15:0] a_wdata, a_rdata;
  logic        a_we, a_txs, a_clr, a_busy, a_tx_led, a_rxin_led, a_rxim_led, a_err;
  logic [3:0]  a_dbg;

  // instance B: 32-bit, IMG 0..0
  logic b_rec_im = 1'b0;
  logic [3:0]  b_addr, b_dbg;
  logic [31:0] b_wdata, b_rdata;
  logic [7:0]  b_txd;
  logic        b_we, b_txs, b_clr, b_busy, b_tx_led, b_rxin_led, b_rxim_led, b_err;

  // instance C: 16-bit, INS 1..1
  logic c_rec_in = 1'b0;
  logic [3:0]  c_addr, c_dbg;
  logic [15:0] c_wdata, c_rdata;
  logic [7:0]  c_txd;
  logic        c_we, c_txs, c_clr, c_busy, c_tx_led, c_rxin_led, c_rxim_led, c_err;

  uart_ram_bridge #(.DATA_W(16), .ADDR_W(8), .TX_START(10), .TX_END(11),
                    .INS_START(1), .INS_END(4), .IMG_START(20), .IMG_END(21)) u_a (
    .clk(clk), .rst_n(rst_n), .send(a_send), .rec_in(a_rec_in), .rec_im(a_rec_im), .abort(a_abort),
    .ram_addr(a_addr), .ram_wdata(a_wdata), .ram_we(a_we), .ram_rdata(a_rdata),
    .uart_tx_data(a_txd), .uart_tx_start(a_txs), .uart_tx_done(tx_done),
    .uart_rx_rdy(rx_rdy), .uart_rx_data(rx_data), .uart_rx_clr(a_clr),
    .busy(a_busy), .tx_led(a_tx_led), .rxin_led(a_rxin_led), .rxim_led(a_rxim_led),
    .err(a_err), .dbg_state(a_dbg));

  uart_ram_bridge #(.DATA_W(32), .ADDR_W(4), .TX_START(1), .TX_END(1),
                    .INS_START(2), .INS_END(2), .IMG_START(0), .IMG_END(0)) u_b (
    .clk(clk), .rst_n(rst_n), .send(1'b0), .rec_in(1'b0), .rec_im(b_rec_im), .abort(1'b0),
    .ram_addr(b_addr), .ram_wdata(b_wdata), .ram_we(b_we), .ram_rdata(b_rdata),
    .uart_tx_data(b_txd), .uart_tx_start(b_txs), .uart_tx_done(tx_done),
    .uart_rx_rdy(rx_rdy), .uart_rx_data(rx_data), .uart_rx_clr(b_clr),
    .busy(b_busy), .tx_led(b_tx_led), .rxin_led(b_rxin_led), .rxim_led(b_rxim_led),
    .err(b_err), .dbg_state(b_dbg));

  uart_ram_bridge #(.DATA_W(16), .ADDR_W(4), .TX_START(2), .TX_END(2),
                    .INS_START(1), .INS_END(1), .IMG_START(3), .IMG_END(3)) u_c (
    .clk(clk), .rst_n(rst_n), .send(1'b0), .rec_in(c_rec_in), .rec_im(1'b0), .abort(1'b0),
    .ram_addr(c_addr), .ram_wdata(c_wdata), .ram_we(c_we), .ram_rdata(c_rdata),
    .uart_tx_data(c_txd), .uart_tx_start(c_txs), .uart_tx_done(tx_done),
    .uart_rx_rdy(rx_rdy), .uart_rx_data(rx_data), .uart_rx_clr(c_clr),
    .busy(c_busy), .tx_led(c_tx_led), .rxin_led(c_rxin_led), .rxim_led(c_rxim_led),
    .err(c_err), .dbg_state(c_dbg));

  // ---------------- RAM models (read data one cycle after address) ----------------
  logic [15:0] mem_a [0:255];
  logic [31:0] mem_b [0:15];
  logic [15:0] mem_c [0:15];
  int a_we_cnt = 0, b_we_cnt = 0, c_we_cnt = 0;

  always @(posedge clk) begin
    if (a_we) begin mem_a[a_addr] <= a_wdata; a_we_cnt <= a_we_cnt + 1; end
    // Words 10 and 11 hold the fixed send image.
    case (a_addr)
      8'd10:   a_rdata <= 16'hA1B2;
      8'd11:   a_rdata <= 16'hC3D4;
      default: a_rdata <= mem_a[a_addr];
    endcase
    if (b_we) begin mem_b[b_addr] <= b_wdata; b_we_cnt <= b_we_cnt + 1; end
    b_rdata <= mem_b[b_addr];
    if (c_we) begin mem_c[c_addr] <= c_wdata; c_we_cnt <= c_we_cnt + 1; end
    c_rdata <= mem_c[c_addr];
  end

  // ---------------- UART transmitter model ----------------
  logic [7:0] tx_log[$];
  int tx_dly = 0;
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (a_txs | b_txs | c_txs) begin
      tx_log.push_back(a_txs ? a_txd : (b_txs ? b_txd : c_txd));
      tx_dly <= 4;
    end else if (tx_dly > 0) begin
      tx_dly  <= tx_dly - 1;
      tx_done <= (tx_dly == 1);
    end
  end

  // ---------------- strobe monitor ----------------
  logic a_we_p = 1'b0, a_txs_p = 1'b0, a_clr_p = 1'b0;
  int wide_cnt = 0;
  always @(posedge clk) begin
    a_we_p  <= a_we;
    a_txs_p <= a_txs;
    a_clr_p <= a_clr;
    if ((a_we && a_we_p) || (a_txs && a_txs_p) || (a_clr && a_clr_p)) wide_cnt <= wide_cnt + 1;
  end

  // ---------------- scoreboard helpers ----------------
  int n_checks = 0, n_errors = 0;
  logic [7:0] ck = 8'h00;
  logic [7:0] ins_bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [7:0] alt_bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic busy_of(input int w);
    case (w)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  task automatic wait_idle(input int w, input string tag);
    int n = 0;
    while (busy_of(w) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy_of(w), 1'b0);
  endtask

  // Presents one byte, waits for the clear strobe, then drops rdy for a cycle.
  task automatic rx_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_rdy  = 1'b1;
    ck      = ck ^ b;
    @(negedge clk);
    while (!(a_clr | b_clr | c_clr) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rx_clr_seen", a_clr | b_clr | c_clr, 1'b1);
    rx_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic rx_finish();
`ifdef UART_BRIDGE_CKSUM_EN
    logic [7:0] c;
    c = ck;
    rx_byte(c);
`endif
    ck = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base, tb, n;
    tick(3);
    check("reset_outputs_a", {a_addr, a_wdata, a_we, a_txd, a_txs, a_clr, a_busy,
                              a_tx_led, a_rxin_led, a_rxim_led, a_err}, '0);
    check("reset_state_a", a_dbg, 4'd0);
    check("reset_outputs_bc", {b_busy, b_err, b_tx_led, b_rxin_led, b_rxim_led, b_dbg,
                               c_busy, c_err, c_tx_led, c_rxin_led, c_rxim_led, c_dbg}, '0);
    rst_n = 1'b1;
    tick(2);
    check("idle_no_start", a_busy, 1'b0);

    // instruction load: 8 bytes into words 1..4
    ck = 8'h00;
    base = a_we_cnt;
    a_rec_in = 1'b1; tick(1); a_rec_in = 1'b0;
    check("ins_start_busy", a_busy, 1'b1);
    check("ins_start_addr", a_addr, 8'd1);
    for (int i = 0; i < 8; i++) rx_byte(ins_bytes[i]);
    rx_finish();
    wait_idle(0, "ins_done");
    check("ins_ram_words", {mem_a[1], mem_a[2], mem_a[3], mem_a[4]}, 64'h1234_5678_9ABC_DEF0);
    check("ins_we_pulses", a_we_cnt - base, 4);
    check("ins_led_err", {a_rxin_led, a_err}, 2'b10);
    check("ins_end_addr", a_addr, 8'd4);

    // send: words 10..11
    tb = tx_log.size();
    a_send = 1'b1; tick(1); a_send = 1'b0;
    check("tx_start_addr", a_addr, 8'd10);
    wait_idle(0, "tx_done");
    check("tx_byte_count", tx_log.size() - tb, 4 + CK_N);
    check("tx_bytes", {tx_log[tb], tx_log[tb+1], tx_log[tb+2], tx_log[tb+3]}, 32'hA1B2_C3D4);
`ifdef UART_BRIDGE_CKSUM_EN
    check("tx_cksum_byte", tx_log[tb+4], 8'h04);
`endif
    check("tx_led", a_tx_led, 1'b1);
    check("tx_end_addr", a_addr, 8'd11);

    // 32-bit image load, single word at address 0
    ck = 8'h00;
    base = b_we_cnt;
    b_rec_im = 1'b1; tick(1); b_rec_im = 1'b0;
    check("img32_busy", b_busy, 1'b1);
    rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h03); rx_byte(8'h04);
    rx_finish();
    wait_idle(1, "img32_done");
    check("img32_word", mem_b[0], 32'h0102_0304);
    check("img32_we_pulses", b_we_cnt - base, 1);
    check("img32_led_addr", {b_rxim_led, b_addr}, {1'b1, 4'd0});

    // simultaneous edges: nothing starts
    a_send = 1'b1; a_rec_im = 1'b1; tick(2);
    check("simul_no_start", {a_busy, a_dbg}, '0);
    check("simul_led_kept", {a_tx_led, a_rxim_led}, 2'b10);
    a_send = 1'b0; a_rec_im = 1'b0; tick(2);

    // send edge during a receive is ignored
    ck = 8'h00;
    tb = tx_log.size();
    a_rec_in = 1'b1; tick(1); a_rec_in = 1'b0;
    rx_byte(alt_bytes[0]); rx_byte(alt_bytes[1]);
    a_send = 1'b1; tick(2); a_send = 1'b0;
    check("busy_send_ignored", {a_busy, a_tx_led}, 2'b11);
    for (int i = 2; i < 8; i++) rx_byte(alt_bytes[i]);
    rx_finish();
    wait_idle(0, "alt_done");
    check("alt_ram_words", {mem_a[1], mem_a[2], mem_a[3], mem_a[4]}, 64'h1122_3344_5566_7788);
    check("alt_no_tx", tx_log.size() - tb, 0);

    // send held high after DONE does not restart
    tb = tx_log.size();
    a_send = 1'b1; tick(1);
    check("held_started", a_busy, 1'b1);
    wait_idle(0, "held_done");
    tick(30);
    check("held_no_restart", {a_busy, a_tx_led}, 2'b01);
    check("held_one_transfer", tx_log.size() - tb, 4 + CK_N);
    a_send = 1'b0; tick(2);

    // abort after 3 of 8 bytes
    ck = 8'h00;
    base = a_we_cnt;
    a_rec_in = 1'b1; tick(1); a_rec_in = 1'b0;
    rx_byte(8'hA0); rx_byte(8'hA1); rx_byte(8'hA2);
    a_abort = 1'b1; tick(1);
    check("abort_idle", a_dbg, 4'd0);
    check("abort_busy_err_led", {a_busy, a_err, a_rxin_led}, 3'b010);
    check("abort_strobes", {a_we, a_txs, a_clr}, 3'b000);
    check("abort_partial_writes", a_we_cnt - base, 1);
    a_abort = 1'b0; ck = 8'h00; tick(3);

    // reset in the middle of a send
    tb = tx_log.size();
    a_send = 1'b1; tick(1); a_send = 1'b0;
    n = 0;
    while (tx_log.size() == tb && n < 200) begin tick(1); n++; end
    check("rst_send_started", tx_log.size() > tb, 1'b1);
    rst_n = 1'b0; tick(1);
    check("rst_idle", a_dbg, 4'd0);
    check("rst_outputs_a", {a_addr, a_wdata, a_we, a_txd, a_txs, a_clr, a_busy,
                            a_tx_led, a_rxin_led, a_rxim_led, a_err}, '0);
    rst_n = 1'b1; tick(20);
    check("rst_no_restart", a_busy, 1'b0);

    // single-word load on instance C (checksum byte when enabled)
    ck = 8'h00;
    c_rec_in = 1'b1; tick(1); c_rec_in = 1'b0;
    rx_byte(8'h12); rx_byte(8'h34);
    rx_finish();
    wait_idle(2, "c_done");
    check("c_word", mem_c[1], 16'h1234);
    check("c_led_err", {c_rxin_led, c_err}, 2'b10);
`ifdef UART_BRIDGE_CKSUM_EN
    c_rec_in = 1'b1; tick(1); c_rec_in = 1'b0;
    rx_byte(8'h12); rx_byte(8'h34); rx_byte(8'h27);
    ck = 8'h00;
    wait_idle(2, "c_bad_done");
    check("c_bad_led_err", {c_rxin_led, c_err}, 2'b11);
`endif

    check("strobes_single_cycle", wide_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
